// File: rtl/pe_pkg.sv
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared types, fixed-point constants and the product-to-operand
//                requantiser used by the PE array and the column drain.
//                Contents:
//                  drain_state_t  - drain controller states
//                  requant()      - saturating floor requantiser, {sat, word}
//                  c_SAT_HI/LO    - product-format saturation thresholds
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pe_pkg;

    localparam int INT_BW  = 5;
    localparam int FRA_BW  = 8;
    localparam int ACC_BW  = 32;
    // Operand word: sign + integer + fraction bits.
    localparam int WORD_BW = INT_BW + FRA_BW + 1;
    // Requantiser result: {sat, word}.
    localparam int RQ_BW   = WORD_BW + 1;

    // Largest and smallest product-format values that fit the operand range.
    localparam logic signed [ACC_BW-1:0] c_SAT_HI =
        ACC_BW'((64'sd1 <<< (INT_BW + 2*FRA_BW)) - 64'sd1);
    localparam logic signed [ACC_BW-1:0] c_SAT_LO =
        ACC_BW'(-(64'sd1 <<< (INT_BW + 2*FRA_BW)));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKEW  = 2'd1,
        CAPT  = 2'd2,
        DRAIN = 2'd3
    } drain_state_t;

    // Saturate to the operand range, otherwise drop the low FRA_BW fraction
    // bits (floor toward minus infinity).
    function automatic logic [RQ_BW-1:0] requant(input logic signed [ACC_BW-1:0] acc);
        logic [RQ_BW-1:0] r;
        if (acc > c_SAT_HI) begin
            r = {1'b1, 1'b0, {(WORD_BW-1){1'b1}}};
        end else if (acc < c_SAT_LO) begin
            r = {1'b1, 1'b1, {(WORD_BW-1){1'b0}}};
        end else begin
            r = {1'b0, acc[INT_BW+2*FRA_BW:FRA_BW]};
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pe_col_drain_if.sv
// ============================================================================
//  Module      : pe_col_drain_if
//  Description : Valid/ready output channel from the column drain to the
//                output buffer.
//                  out_data  - requantised word, sign-extended
//                  out_sat   - word was saturated
//                  out_valid - word available
//                  out_ready - consumer accepts this cycle
//                master: drain side, slave: consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pe_col_drain_if #(
    parameter int MUL_BW = 16
) ();

    logic signed [MUL_BW-1:0] out_data;
    logic                     out_sat;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output out_data,
        output out_sat,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_sat,
        input  out_valid,
        output out_ready
    );

endinterface

`default_nettype wire

// File: rtl/raven_sync_fifo.sv
// ============================================================================
//  Module      : raven_sync_fifo
//  Description : Single-clock fall-through FIFO. Pointers carry one extra
//                wrap bit so full and empty are distinguishable. A push while
//                full is accepted when a pop happens on the same edge.
//                  clk, rst    - clock, asynchronous active-high reset
//                  push, din   - write request and data
//                  pop         - read request (ignored when empty)
//                  dout        - head entry, valid while !empty
//                  full, empty - occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module raven_sync_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
    end

    assign dout  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/pe_col_drain.sv
// ============================================================================
//  Module      : pe_col_drain
//  Description : Bottom-of-column result drain. After a programmed skew it
//                captures len results from the column stream, requantises
//                them, buffers them and drains them over valid/ready.
//                  clk, rst   - clock, asynchronous active-high reset
//                  start      - job start, ignored while busy
//                  skew, len  - job programming, sampled with start
//                  o_i        - result stream from the bottom PE
//                  dout_if    - output channel (master)
//                  busy       - job in progress
//                  done       - one-cycle completion pulse
//                  ovf        - sticky dropped-capture flag
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pe_col_drain
    import pe_pkg::*;
#(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 8,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_BW = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     start,
    input  wire logic        [CNT_BW-1:0] skew,
    input  wire logic        [CNT_BW-1:0] len,
    input  wire logic signed [ACC_BW-1:0] o_i,
    pe_col_drain_if.master                dout_if,
    output logic                          busy,
    output logic                          done,
    output logic                          ovf
);

    // The requantiser lives in pe_pkg and is built for the package's
    // INT_BW/FRA_BW/ACC_BW; these parameters must match it.
    localparam int c_WORD_BW = INT_BW + FRA_BW + 1;
    localparam int c_ENT_BW  = c_WORD_BW + 1;
    localparam int c_OCC_BW  = $clog2(DEPTH) + 1;

    drain_state_t        r_state;
    drain_state_t        w_state_nxt;
    logic [CNT_BW-1:0]   r_skew_cnt;
    logic [CNT_BW-1:0]   w_skew_cnt_nxt;
    logic [CNT_BW-1:0]   r_len_cnt;
    logic [CNT_BW-1:0]   w_len_cnt_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_ovf;
    logic                w_ovf_nxt;
    logic [c_OCC_BW-1:0] r_occ;

    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_drained;
    logic                w_full;
    logic                w_empty;
    logic [c_ENT_BW-1:0] w_din;
    logic [c_ENT_BW-1:0] w_dout;

    assign w_din  = requant(o_i);
    assign w_push = (r_state == CAPT);
    assign w_pop  = dout_if.out_ready & ~w_empty;
    // A same-edge pop frees the slot, so only a full FIFO with no pop drops.
    assign w_drop = w_push & w_full & ~w_pop;
    // FIFO is empty after this edge (no pushes happen outside CAPT).
    assign w_drained = w_empty | (w_pop & (r_occ == c_OCC_BW'(1)));

    raven_sync_fifo #(
        .WIDTH (c_ENT_BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_skew_cnt <= '0;
            r_len_cnt  <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_skew_cnt <= w_skew_cnt_nxt;
            r_len_cnt  <= w_len_cnt_nxt;
            r_done     <= w_done_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    // Occupancy mirror, needed to see the FIFO going empty on a pop edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + c_OCC_BW'(w_push & ~w_drop) - c_OCC_BW'(w_pop);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_skew_cnt_nxt = r_skew_cnt;
        w_len_cnt_nxt  = r_len_cnt;
        w_done_nxt     = 1'b0;
        w_ovf_nxt      = r_ovf | w_drop;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_len_cnt_nxt  = len;
                        w_skew_cnt_nxt = skew;
                        w_ovf_nxt      = 1'b0;
                        w_state_nxt    = (skew != '0) ? SKEW : CAPT;
                    end
                end
            end
            SKEW: begin
                w_skew_cnt_nxt = r_skew_cnt - CNT_BW'(1);
                if (r_skew_cnt == CNT_BW'(1)) w_state_nxt = CAPT;
            end
            CAPT: begin
                // One capture per edge; the count advances even on a drop.
                w_len_cnt_nxt = r_len_cnt - CNT_BW'(1);
                if (r_len_cnt == CNT_BW'(1)) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_drained) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Head is forced to zero when empty so reset never exposes stale storage.
    assign dout_if.out_valid = ~w_empty;
    assign dout_if.out_sat   = ~w_empty & w_dout[c_WORD_BW];
    assign dout_if.out_data  = w_empty ? '0 :
        {{(MUL_BW-c_WORD_BW){w_dout[c_WORD_BW-1]}}, w_dout[c_WORD_BW-1:0]};

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pe_col_drain.sv
// ============================================================================
//  Module      : tb_pe_col_drain
//  Description : Self-checking bench for pe_col_drain. A queue-based job
//                model predicts the output channel and status every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pe_col_drain;

    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic        [7:0]  skew;
    logic        [7:0]  len;
    logic signed [31:0] o_i;
    logic               busy;
    logic               done;
    logic               ovf;

    pe_col_drain_if #(.MUL_BW(16)) dif ();

    pe_col_drain #(
        .INT_BW (5), .FRA_BW (8), .MUL_BW (16),
        .ACC_BW (32), .DEPTH (DEPTH), .CNT_BW (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .skew    (skew),
        .len     (len),
        .o_i     (o_i),
        .dout_if (dif),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    typedef struct { logic [15:0] data; logic sat; } ent_t;
    ent_t mq[$];
    bit   m_active = 0;
    bit   m_done   = 0;
    bit   m_ovf    = 0;
    int   m_first  = 0;
    int   m_last   = 0;
    int   edge_n   = 0;

    // Q5.16 -> Q5.8 with saturation, via integer arithmetic.
    function automatic ent_t ref_requant(input logic signed [31:0] acc);
        ent_t   r;
        longint a;
        longint f;
        a = acc;
        if (a > 64'sd2097151) begin
            r.data = 16'h1FFF; r.sat = 1'b1;
        end else if (a < -64'sd2097152) begin
            r.data = 16'hE000; r.sat = 1'b1;
        end else begin
            f = a >>> 8;
            r.data = f[15:0]; r.sat = 1'b0;
        end
        return r;
    endfunction

    function automatic logic signed [31:0] rand_acc();
        logic signed [31:0] bnd [6];
        int unsigned sel;
        bnd = '{32'sd2097151, 32'sd2097152, -32'sd2097152, -32'sd2097153, 32'sd0, -32'sd1};
        sel = $urandom_range(0, 5);
        if (sel == 0) return $urandom;
        if (sel == 1) return bnd[$urandom_range(0, 5)];
        return 32'($urandom_range(0, 32'h003F_FFFF)) - 32'sd2097152;
    endfunction

    function automatic logic [20:0] dut_vec();
        return {dif.out_valid, dif.out_data, dif.out_sat, busy, done, ovf};
    endfunction

    function automatic logic [20:0] exp_vec();
        if (mq.size() > 0)
            return {1'b1, mq[0].data, mq[0].sat, m_active, m_done, m_ovf};
        return {1'b0, 16'h0000, 1'b0, m_active, m_done, m_ovf};
    endfunction

    // Advance one clock; the model consumes the inputs held before the edge.
    task automatic step();
        bit                 s_rst   = rst;
        bit                 s_start = start;
        logic        [7:0]  s_skew  = skew;
        logic        [7:0]  s_len   = len;
        logic signed [31:0] s_oi    = o_i;
        bit                 s_rdy   = dif.out_ready;
        @(posedge clk);
        edge_n++;
        if (s_rst) begin
            mq.delete(); m_active = 0; m_done = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (s_rdy && mq.size() > 0) void'(mq.pop_front());
            if (m_active) begin
                if (edge_n >= m_first && edge_n <= m_last) begin
                    if (mq.size() < DEPTH) mq.push_back(ref_requant(s_oi));
                    else m_ovf = 1;
                end else if (edge_n > m_last && mq.size() == 0) begin
                    m_done = 1; m_active = 0;
                end
            end else if (s_start) begin
                if (s_len == 0) m_done = 1;
                else begin
                    m_active = 1;
                    m_first  = edge_n + int'(s_skew) + 1;
                    m_last   = edge_n + int'(s_skew) + int'(s_len);
                    m_ovf    = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; start = 0; skew = 0; len = 0; o_i = 0; dif.out_ready = 0;
        step(); step();
        n_checks++;
        if (dut_vec() !== 21'h0) $display("FAIL reset_outputs got=%h want=%h", dut_vec(), 21'h0);
        else n_pass++;
        rst = 0;
        step();
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_release got=%h want=%h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_basic();
        int e0; int first_v = -1; int pops = 0; int last_pop = -1; int done_e = -1; int n_done = 0;
        dif.out_ready = 1; o_i = 32'h0001_2345; skew = 2; len = 3; start = 1;
        step(); e0 = edge_n; start = 0;
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL basic_cycle edge=%0d got=%h want=%h", edge_n, dut_vec(), exp_vec());
            else n_pass++;
            if (dif.out_valid && first_v < 0) first_v = edge_n;
            if (done) begin n_done++; if (done_e < 0) done_e = edge_n; end
            if (dif.out_valid && dif.out_ready) begin
                pops++; last_pop = edge_n + 1;
                n_checks++;
                if ({dif.out_data, dif.out_sat} !== {16'h0123, 1'b0})
                    $display("FAIL basic_word got=%h/%b want=0123/0", dif.out_data, dif.out_sat);
                else n_pass++;
            end
            step();
        end
        n_checks++;
        if (first_v - e0 !== 3) $display("FAIL basic_first_valid got=%0d want=3", first_v - e0);
        else n_pass++;
        n_checks++;
        if (pops !== 3) $display("FAIL basic_pops got=%0d want=3", pops);
        else n_pass++;
        n_checks++;
        if (done_e !== last_pop || n_done !== 1)
            $display("FAIL basic_done got=%0d/%0d want=%0d/1", done_e, n_done, last_pop);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic signed [31:0] vals [3];
        logic [16:0]        want [3];
        vals = '{32'h0020_0000, 32'hFFDF_FFFF, 32'hFFFF_FF00};
        want = '{{16'h1FFF, 1'b1}, {16'hE000, 1'b1}, {16'hFFFF, 1'b0}};
        dif.out_ready = 0; skew = 0; len = 3; start = 1;
        step(); start = 0;
        for (int k = 0; k < 3; k++) begin
            o_i = vals[k];
            step();
        end
        dif.out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({dif.out_data, dif.out_sat} !== want[k])
                $display("FAIL sat_word%0d got=%h want=%h", k, {dif.out_data, dif.out_sat}, want[k]);
            else n_pass++;
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL sat_cycle edge=%0d got=%h want=%h", edge_n, dut_vec(), exp_vec());
            else n_pass++;
            step();
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL sat_tail edge=%0d got=%h want=%h", edge_n, dut_vec(), exp_vec());
            else n_pass++;
            step();
        end
    endtask

    task automatic test_overflow();
        int pops = 0; bit seen = 0;
        dif.out_ready = 0; skew = 1; len = 10; start = 1;
        step(); start = 0;
        for (int k = 0; k < 12; k++) begin
            o_i = rand_acc();
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL ovf_capture edge=%0d got=%h want=%h", edge_n, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({ovf, busy, dif.out_valid} !== 3'b111) $display("FAIL ovf_flag got=%b want=111", {ovf, busy, dif.out_valid});
        else n_pass++;
        dif.out_ready = 1;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (dif.out_valid) pops++;
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL ovf_drain edge=%0d got=%h want=%h", edge_n, dut_vec(), exp_vec());
            else n_pass++;
            if (done) seen = 1;
        end
        n_checks++;
        if (!seen) $display("FAIL ovf_done_timeout got=0 want=1");
        else n_pass++;
        n_checks++;
        if (pops !== 8) $display("FAIL ovf_pops got=%0d want=8", pops);
        else n_pass++;
        step();
        n_checks++;
        if (ovf !== 1'b1) $display("FAIL ovf_sticky got=%b want=1", ovf);
        else n_pass++;
    endtask

    task automatic test_full_pushpop();
        int e0; int pops = 0; bit seen = 0;
        dif.out_ready = 0; skew = 0; len = 20; start = 1;
        step(); e0 = edge_n; start = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            o_i = rand_acc();
            dif.out_ready = (edge_n >= e0 + 8);
            if (dif.out_valid && dif.out_ready) pops++;
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL full_cycle edge=%0d got=%h want=%h", edge_n, dut_vec(), exp_vec());
            else n_pass++;
            if (done) seen = 1;
        end
        n_checks++;
        if (!seen || pops !== 20 || ovf !== 1'b0)
            $display("FAIL full_summary got=done%b/pops%0d/ovf%b want=done1/pops20/ovf0", seen, pops, ovf);
        else n_pass++;
    endtask

    task automatic test_edge_jobs();
        int pops = 0; bit seen = 0;
        dif.out_ready = 1; skew = 3; len = 0; start = 1;
        step(); start = 0;
        n_checks++;
        if ({done, busy} !== 2'b10) $display("FAIL len0_done got=%b want=10", {done, busy});
        else n_pass++;
        step();
        n_checks++;
        if ({done, busy} !== 2'b00) $display("FAIL len0_after got=%b want=00", {done, busy});
        else n_pass++;
        skew = 0; len = 4; start = 1;
        step(); start = 0;
        step();
        start = 1; len = 1; skew = 0;
        step(); start = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            o_i = rand_acc();
            if (dif.out_valid) pops++;
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL busy_start edge=%0d got=%h want=%h", edge_n, dut_vec(), exp_vec());
            else n_pass++;
            if (done) seen = 1;
        end
        n_checks++;
        if (!seen || pops !== 3) $display("FAIL busy_start_pops got=%0d want=3 (plus 1 popped before)", pops);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int pops = 0; bit seen = 0;
        dif.out_ready = 0; skew = 1; len = 6; start = 1;
        step(); start = 0;
        for (int k = 0; k < 3; k++) begin o_i = rand_acc(); step(); end
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL rstmid_before got=%h want=%h", dut_vec(), exp_vec());
        else n_pass++;
        rst = 1;
        #1;
        n_checks++;
        if (dut_vec() !== 21'h0) $display("FAIL rstmid_immediate got=%h want=%h", dut_vec(), 21'h0);
        else n_pass++;
        step();
        rst = 0;
        step();
        dif.out_ready = 1; skew = 0; len = 3; start = 1;
        step(); start = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            o_i = rand_acc();
            if (dif.out_valid) pops++;
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL rstmid_after edge=%0d got=%h want=%h", edge_n, dut_vec(), exp_vec());
            else n_pass++;
            if (done) seen = 1;
        end
        n_checks++;
        if (!seen || pops !== 3) $display("FAIL rstmid_job got=done%b/pops%0d want=done1/pops3", seen, pops);
        else n_pass++;
    endtask

    task automatic test_random();
        bit idle;
        for (int j = 0; j < 8; j++) begin
            skew = 8'($urandom_range(0, 4));
            len  = 8'($urandom_range(0, 14));
            start = 1;
            idle = 0;
            for (int k = 0; k < 300 && !idle; k++) begin
                o_i = rand_acc();
                dif.out_ready = ($urandom_range(0, 3) != 0);
                step();
                n_checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL random_cycle job=%0d edge=%0d got=%h want=%h", j, edge_n, dut_vec(), exp_vec());
                else n_pass++;
                // Random starts while busy must be ignored.
                start = m_active && ($urandom_range(0, 7) == 0);
                len   = 8'($urandom_range(0, 14));
                if (!m_active && mq.size() == 0) idle = 1;
            end
            start = 0;
            n_checks++;
            if (!idle) $display("FAIL random_timeout job=%0d got=busy want=idle", j);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_overflow();
        test_full_pushpop();
        test_edge_jobs();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
